ss_capture: RTL and testbench
=============================

Name: ss_capture

Overview:
- Monitors a multiplexed, active-low seven-segment bus: 4 anode strobes, 7 segments, decimal point.
- Recovers the hex digit being displayed on each position and assembles a 16-bit value.
- Sits on the loopback/debug side of the display path: the receiver for the board's nibble-to-segment decoders. Lets the game logic and the bench confirm what the score display actually shows.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the an/seg/dp inputs (≥2).
- STABLE_CYC, 16, consecutive identical samples required before a digit is accepted (≥2).
- TIMEOUT_CYC, 2000000, cycles without any accepted digit before stale asserts.
- CW, 21, width of the timeout counter (must hold TIMEOUT_CYC).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- an  in  4  anode strobes, active-low; an[i]=0 selects digit i (0 = rightmost)
- seg  in  7  segments, active-low; seg[0]=A … seg[6]=G
- dp  in  1  decimal point, active-low
- value  out  16  last complete frame; digit i at value[4i+3:4i]
- dp_flags  out  4  dp lit state per digit for the last complete frame
- blank  out  4  digit showed all segments off in the last complete frame
- frame_valid  out  1  one-cycle pulse when value/dp_flags/blank update
- pat_err  out  1  sticky: an unrecognized non-blank pattern was accepted; cleared by reset only
- stale  out  1  high while no digit has been accepted for TIMEOUT_CYC cycles

Behaviour:
- Reset (asynchronous, any time, including mid-settle):
  - value=0, dp_flags=0, blank=4'hF, frame_valid=0, pat_err=0, stale=0.
  - Synchronizers to all ones; stability counter 0; seen mask 0; shadow registers 0; FSM to IDLE.
- Decode table, seg hex (active-low, {G..A}) → nibble:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 58→7, 00→8, 10→9, 20→A, 03→b, 46→c, 21→d, 06→E, 0E→F.
  - 7F = blank.
  - Any other pattern: set pat_err, leave the slot's previous nibble unchanged, still mark the slot seen.
- Sample: the synchronized {an,seg,dp} vector. Legal only when exactly one an bit is 0.
- FSM:
  - IDLE: legal sample → load ref=sample, cnt=1, go SETTLE.
  - SETTLE: sample==ref → cnt++; when cnt reaches STABLE_CYC → CAPTURE. Sample≠ref (including an illegal anode pattern) → back to IDLE, cnt=0, no write.
  - CAPTURE (1 cycle): write shadow nibble/dp/blank for slot i; set seen[i]; reset timeout counter; go HOLD.
  - HOLD: stay while sample==ref, so one strobe period gives one capture. Any change → IDLE, and the same cycle is evaluated as an IDLE sample.
- Frame:
  - When a CAPTURE makes seen==4'hF, on the next clock copy the shadow (including that write) to value/dp_flags/blank, pulse frame_valid, clear seen.
  - A capture of an already-seen slot just overwrites the shadow.
- Latency: input change to frame_valid for the final digit = SYNC_STAGES + STABLE_CYC + 2 cycles.
- Timeout:
  - Counter increments every cycle and saturates at TIMEOUT_CYC; stale = (counter==TIMEOUT_CYC).
  - Cleared by any CAPTURE. Outputs keep their last frame while stale.
- Simultaneous events: a reset on the same edge as CAPTURE wins; nothing is written.

Test Plan:
1. Scan digits 1,2,3,4 (an=E,D,B,7), seg=79,24,30,19, 40 cycles each, dp=1 → one frame_valid pulse, value=16'h4321, dp_flags=0, blank=0, pat_err=0.
2. Digit 0 segments glitch 40→00 for 5 cycles inside a STABLE_CYC window → no capture; after 16 stable cycles of 40 it captures 0. Next frame value[3:0]=0, not 8.
3. an=4'hC (two digits selected) for 100 cycles → no capture, seen unchanged, no frame_valid.
4. Digit 2 shows seg=7F, digit 1 shows seg=55 (illegal), dp=0 on digit 3 → blank=4'b0100, pat_err=1, value[7:4] keeps its prior nibble, dp_flags=4'b1000.
5. Hold an=4'hF for TIMEOUT_CYC cycles → stale=1 on that exact cycle; the next accepted digit drops stale the cycle after CAPTURE.
6. Assert rst mid-SETTLE after 3 of 4 digits seen → outputs return to reset values immediately. A full scan afterwards produces exactly one frame_valid.

Source files
------------

// File: rtl/ss_capture.sv
// Seven-segment bus receiver: recovers the hex digit shown on each of four
// multiplexed positions and assembles them into a 16-bit frame.
module ss_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int CW          = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] value,
    output logic [3:0]  dp_flags,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        pat_err,
    output logic        stale
);
    localparam int CNTW = $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

    // Active-low segment code {G..A} to {valid, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h00;
        case (s)
            7'h40: r = {1'b1, 4'h0};
            7'h79: r = {1'b1, 4'h1};
            7'h24: r = {1'b1, 4'h2};
            7'h30: r = {1'b1, 4'h3};
            7'h19: r = {1'b1, 4'h4};
            7'h12: r = {1'b1, 4'h5};
            7'h02: r = {1'b1, 4'h6};
            7'h58: r = {1'b1, 4'h7};
            7'h00: r = {1'b1, 4'h8};
            7'h10: r = {1'b1, 4'h9};
            7'h20: r = {1'b1, 4'hA};
            7'h03: r = {1'b1, 4'hB};
            7'h46: r = {1'b1, 4'hC};
            7'h21: r = {1'b1, 4'hD};
            7'h06: r = {1'b1, 4'hE};
            7'h0E: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [SYNC_STAGES-1:0][11:0] sync_q, sync_d;
    state_t                       state_q, state_d;
    logic [11:0]                  ref_q, ref_d;
    logic [CNTW-1:0]              cnt_q, cnt_d;
    logic [3:0]                   seen_q, seen_d;
    logic [3:0][3:0]              nib_q, nib_d;
    logic [3:0]                   sdp_q, sdp_d;
    logic [3:0]                   sblank_q, sblank_d;
    logic                         frame_pend_q, frame_pend_d;
    logic [15:0]                  value_q, value_d;
    logic [3:0]                   dp_flags_q, dp_flags_d;
    logic [3:0]                   blank_q, blank_d;
    logic                         frame_valid_q, frame_valid_d;
    logic                         pat_err_q, pat_err_d;
    logic [CW-1:0]                tmo_q, tmo_d;

    logic [11:0] sample;
    logic        legal;
    logic [4:0]  dec;
    logic [1:0]  slot;
    logic [3:0]  slot_mask;

    assign sample    = sync_q[SYNC_STAGES-1];
    assign legal     = (sample[11:8] == 4'hE) || (sample[11:8] == 4'hD) ||
                       (sample[11:8] == 4'hB) || (sample[11:8] == 4'h7);
    assign dec       = decode(ref_q[7:1]);
    assign slot_mask = ~ref_q[11:8];

    // Shift the raw bus through the synchronizer chain.
    always_comb begin
        sync_d[0] = {an, seg, dp};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    // Digit position held in the reference sample (only legal samples are loaded).
    always_comb begin
        case (ref_q[11:8])
            4'hD:    slot = 2'd1;
            4'hB:    slot = 2'd2;
            4'h7:    slot = 2'd3;
            default: slot = 2'd0;
        endcase
    end

    // Settle/capture FSM: next state, reference sample and stability count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    ref_d   = sample;
                    cnt_d   = CNTW'(1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sample == ref_q) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == CNTW'(STABLE_CYC)) state_d = CAPTURE;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            CAPTURE: state_d = HOLD;
            HOLD: begin
                // A change is judged as a fresh IDLE sample in the same cycle.
                if (sample != ref_q) begin
                    if (legal) begin
                        ref_d   = sample;
                        cnt_d   = CNTW'(1);
                        state_d = SETTLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow write on capture, frame publish one cycle after the last slot, timeout.
    always_comb begin
        nib_d         = nib_q;
        sdp_d         = sdp_q;
        sblank_d      = sblank_q;
        pat_err_d     = pat_err_q;
        seen_d        = frame_pend_q ? 4'h0 : seen_q;
        frame_pend_d  = 1'b0;
        value_d       = value_q;
        dp_flags_d    = dp_flags_q;
        blank_d       = blank_q;
        frame_valid_d = frame_pend_q;
        tmo_d         = (tmo_q == CW'(TIMEOUT_CYC)) ? tmo_q : tmo_q + 1'b1;

        if (frame_pend_q) begin
            value_d    = nib_q;
            dp_flags_d = sdp_q;
            blank_d    = sblank_q;
        end

        if (state_q == CAPTURE) begin
            sdp_d[slot] = ~ref_q[0];
            if (dec[4]) begin
                nib_d[slot]    = dec[3:0];
                sblank_d[slot] = 1'b0;
            end else if (ref_q[7:1] == 7'h7F) begin
                sblank_d[slot] = 1'b1;
            end else begin
                // Unknown pattern: nibble keeps its previous value.
                sblank_d[slot] = 1'b0;
                pat_err_d      = 1'b1;
            end
            seen_d       = seen_d | slot_mask;
            frame_pend_d = ((seen_d | slot_mask) == 4'hF);
            tmo_d        = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q        <= '1;
            state_q       <= IDLE;
            ref_q         <= '0;
            cnt_q         <= '0;
            seen_q        <= '0;
            // NOTE: shadow digit storage is reset too, so a partial frame never publishes stale contents.
            nib_q         <= '0;
            sdp_q         <= '0;
            sblank_q      <= '0;
            frame_pend_q  <= 1'b0;
            value_q       <= '0;
            dp_flags_q    <= '0;
            blank_q       <= 4'hF;
            frame_valid_q <= 1'b0;
            pat_err_q     <= 1'b0;
            tmo_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_q        <= sync_d;
            state_q       <= state_d;
            ref_q         <= ref_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            nib_q         <= nib_d;
            sdp_q         <= sdp_d;
            sblank_q      <= sblank_d;
            frame_pend_q  <= frame_pend_d;
            value_q       <= value_d;
            dp_flags_q    <= dp_flags_d;
            blank_q       <= blank_d;
            frame_valid_q <= frame_valid_d;
            pat_err_q     <= pat_err_d;
            tmo_q         <= tmo_d;
        end
    end

    assign value       = value_q;
    assign dp_flags    = dp_flags_q;
    assign blank       = blank_q;
    assign frame_valid = frame_valid_q;
    assign pat_err     = pat_err_q;
    assign stale       = (tmo_q == CW'(TIMEOUT_CYC));

endmodule

// File: tb/tb_ss_capture.sv
// Bench for ss_capture: display-level model feeds a frame scoreboard; a
// monitor compares every frame_valid pulse against the queued expectation.
module tb_ss_capture;
    localparam int SYNC   = 2;
    localparam int STABLE = 16;
    localparam int TMO    = 300;
    localparam int CW     = 9;
    localparam int LAT    = SYNC + STABLE + 2;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
        7'h00, 7'h10, 7'h20, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] value;
    logic [3:0]  dp_flags;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        pat_err;
    logic        stale;

    ss_capture #(
        .SYNC_STAGES(SYNC), .STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
        .value(value), .dp_flags(dp_flags), .blank(blank),
        .frame_valid(frame_valid), .pat_err(pat_err), .stale(stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dpf;
        logic [3:0]  blank;
        logic        perr;
    } frame_t;

    frame_t exp_q[$];
    int checks = 0;
    int passed = 0;
    int frames_seen = 0;
    int last_fv_cyc = -1;
    int t_start = 0;

    // Display-level model: what the receiver has accepted so far.
    logic [3:0]  m_nib [4];
    logic [3:0]  m_dp, m_blank, m_seen;
    logic        m_perr;
    logic [11:0] m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_legal(input logic [3:0] a);
        return (a == 4'hE) || (a == 4'hD) || (a == 4'hB) || (a == 4'h7);
    endfunction

    function automatic int code_idx(input logic [6:0] s);
        int idx = -1;
        for (int k = 0; k < 16; k++) if (SEG_TAB[k] == s) idx = k;
        return idx;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_dp = 4'h0; m_blank = 4'h0; m_seen = 4'h0; m_perr = 1'b0;
        m_prev = 12'hFFF;
    endtask

    // Drive a new bus value; if it will be held long enough and is a genuine
    // change to a single selected digit, the receiver accepts it once.
    task automatic apply(input logic [3:0] a, input logic [6:0] s, input logic d, input bit long_hold);
        logic [11:0] v;
        int slot, idx;
        frame_t f;
        v = {a, s, d};
        an = a; seg = s; dp = d;
        t_start = cyc;
        if (long_hold && v != m_prev && is_legal(a)) begin
            slot = (a == 4'hE) ? 0 : (a == 4'hD) ? 1 : (a == 4'hB) ? 2 : 3;
            idx = code_idx(s);
            m_dp[slot] = ~d;
            if (idx >= 0) begin
                m_nib[slot] = idx[3:0];
                m_blank[slot] = 1'b0;
            end else if (s == 7'h7F) begin
                m_blank[slot] = 1'b1;
            end else begin
                m_blank[slot] = 1'b0;
                m_perr = 1'b1;
            end
            m_seen[slot] = 1'b1;
            if (m_seen == 4'hF) begin
                f.value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                f.dpf = m_dp; f.blank = m_blank; f.perr = m_perr;
                exp_q.push_back(f);
                m_seen = 4'h0;
            end
        end
        m_prev = v;
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic d, input int dur);
        apply(a, s, d, dur >= 20);
        repeat (dur) @(negedge clk);
    endtask

    task automatic rand_digit(output logic [3:0] a, output logic [6:0] s, output logic d);
        int kind;
        a = ~(4'b0001 << $urandom_range(0, 3));
        d = 1'($urandom_range(0, 1));
        kind = $urandom_range(0, 9);
        if (kind == 0) s = 7'h7F;
        else if (kind == 1) begin
            do s = 7'($urandom); while (code_idx(s) >= 0 || s == 7'h7F);
        end else s = SEG_TAB[$urandom_range(0, 15)];
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"}, value, 16'h0);
        check({tag, "_dp_flags"}, dp_flags, 4'h0);
        check({tag, "_blank"}, blank, 4'hF);
        check({tag, "_frame_valid"}, frame_valid, 1'b0);
        check({tag, "_pat_err"}, pat_err, 1'b0);
        check({tag, "_stale"}, stale, 1'b0);
    endtask

    // Monitor: every frame_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        frame_t f;
        if (!rst && frame_valid) begin
            frames_seen++;
            last_fv_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_frame: got value %h with no frame expected (t=%0t)", value, $time);
            end else begin
                f = exp_q.pop_front();
                check("frame_value", value, f.value);
                check("frame_dp_flags", dp_flags, f.dpf);
                check("frame_blank", blank, f.blank);
                check("frame_pat_err", pat_err, f.perr);
            end
        end
    end

    initial begin
        int n, t0, t1;
        logic [3:0] a;
        logic [6:0] s, gs;
        logic d;

        model_reset();
        rst = 1'b1; an = 4'hF; seg = 7'h7F; dp = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: plain scan 1,2,3,4 and end-to-end latency of the last digit.
        n = frames_seen;
        step(4'hE, 7'h79, 1'b1, 40);
        step(4'hD, 7'h24, 1'b1, 40);
        step(4'hB, 7'h30, 1'b1, 40);
        step(4'h7, 7'h19, 1'b1, 40);
        check("t1_frames", frames_seen - n, 1);
        check("t1_latency", last_fv_cyc - t_start, LAT);
        check("t1_value", value, 16'h4321);
        check("t1_dp_flags", dp_flags, 4'h0);
        check("t1_blank", blank, 4'h0);

        // Test 2: short glitch inside the settle window must not capture an 8.
        step(4'hE, 7'h40, 1'b1, 8);
        step(4'hE, 7'h00, 1'b1, 5);
        step(4'hE, 7'h40, 1'b1, 40);
        step(4'hD, 7'h24, 1'b1, 40);
        step(4'hB, 7'h30, 1'b1, 40);
        step(4'h7, 7'h19, 1'b1, 40);
        check("t2_value", value, 16'h4320);

        // Test 3: two anodes selected at once is ignored and keeps seen intact.
        step(4'hE, 7'h79, 1'b1, 40);
        step(4'hD, 7'h24, 1'b1, 40);
        n = frames_seen;
        step(4'hC, 7'h30, 1'b1, 100);
        check("t3_no_frame", frames_seen - n, 0);
        step(4'hB, 7'h30, 1'b1, 40);
        step(4'h7, 7'h19, 1'b1, 40);
        check("t3_frames", frames_seen - n, 1);
        check("t3_pat_err_clear", pat_err, 1'b0);

        // Test 4: blank digit, unknown pattern and a lit decimal point.
        step(4'hE, 7'h79, 1'b1, 40);
        step(4'hD, 7'h55, 1'b1, 40);
        step(4'hB, 7'h7F, 1'b1, 40);
        step(4'h7, 7'h19, 1'b0, 40);
        check("t4_blank", blank, 4'b0100);
        check("t4_pat_err", pat_err, 1'b1);
        check("t4_nibble1_kept", value[7:4], 4'h2);
        check("t4_dp_flags", dp_flags, 4'b1000);

        // Randomized scans with illegal anodes and short glitches.
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                a = (it % 2 == 0) ? 4'hC : 4'h0;
                step(a, 7'($urandom), 1'($urandom_range(0, 1)), $urandom_range(20, 40));
            end else begin
                rand_digit(a, s, d);
                if (r == 1) begin
                    gs = s ^ (7'b1 << $urandom_range(0, 6));
                    if ({a, gs, d} != m_prev) step(a, gs, d, $urandom_range(1, 5));
                end
                step(a, s, d, $urandom_range(20, 50));
            end
        end

        // Test 5: stale rises exactly TIMEOUT cycles after the last capture.
        step(4'hF, 7'h7F, 1'b1, 30);
        apply(4'hE, 7'h12, 1'b1, 1'b1);
        t0 = t_start;
        repeat (30) @(negedge clk);
        apply(4'hF, 7'h7F, 1'b1, 1'b0);
        while (cyc < t0 + SYNC + STABLE + TMO) @(negedge clk);
        check("t5_stale_before", stale, 1'b0);
        @(negedge clk);
        check("t5_stale_rise", stale, 1'b1);
        repeat (5) @(negedge clk);
        check("t5_stale_saturated", stale, 1'b1);
        apply(4'hD, 7'h24, 1'b1, 1'b1);
        t1 = t_start;
        while (cyc < t1 + SYNC + STABLE) @(negedge clk);
        check("t5_stale_in_capture", stale, 1'b1);
        @(negedge clk);
        check("t5_stale_drop", stale, 1'b0);
        repeat (25) @(negedge clk);

        // Test 6: reset in mid-settle after three digits of a fresh frame.
        for (int k = 0; k < 4 && m_seen != 4'h0; k++) begin
            if (!m_seen[k]) step(~(4'b0001 << k), SEG_TAB[k + 5], 1'b1, 40);
        end
        step(4'hE, 7'h02, 1'b1, 40);
        step(4'hD, 7'h58, 1'b1, 40);
        step(4'hB, 7'h00, 1'b1, 40);
        check("t6_queue_drained", exp_q.size(), 0);
        apply(4'h7, 7'h10, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_outputs("t6_reset");
        model_reset();
        apply(4'hF, 7'h7F, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = frames_seen;
        step(4'hE, 7'h79, 1'b1, 40);
        step(4'hD, 7'h24, 1'b1, 40);
        step(4'hB, 7'h30, 1'b1, 40);
        step(4'h7, 7'h19, 1'b1, 40);
        check("t6_one_frame", frames_seen - n, 1);

        repeat (30) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
